elastic_pipe: RTL and testbench
===============================

ELASTIC_PIPE -- requirements
Module: elastic_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages (>=1).
REQ-003 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-004 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: flush  in  1  synchronous discard of all held words.
REQ-006 SHALL have ports: in_valid  in  1; in_ready  out  1; in_data  in  WIDTH (upstream valid/ready channel).
REQ-007 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  WIDTH (downstream channel).
REQ-008 SHALL have port: occupancy  out  CNT_W = clog2(DEPTH+2)  number of valid words held.

Function
REQ-009 SHALL transfer a word when valid and ready are both high at a rising edge; no other condition transfers.
REQ-010 SHALL hold per stage i a valid bit v[i] and data reg d[i]; stage DEPTH-1 drives out_valid/out_data.
REQ-011 SHALL compute stage advance en[DEPTH-1] = !v[DEPTH-1] | out_ready; en[i] = !v[i] | en[i+1] (bubble collapsing).
REQ-012 SHALL, when en[i], load v[i] from v[i-1] (stage 0: accepted input valid); d[i] loads only when en[i] and upstream valid, else holds.
REQ-013 SHALL drive in_ready = en[0] (without skid option); combinational path out_ready -> in_ready permitted only then.
REQ-014 SHALL give latency exactly DEPTH cycles from input transfer to out_valid on an unstalled pipe, throughput 1 word/cycle.
REQ-015 SHALL preserve word order and never drop or duplicate a word while out_ready is low (out_data/out_valid stable until transfer).
REQ-016 SHALL, while flush=1, force in_ready=0 and out_valid=0 that cycle and clear all valid bits at the edge; data regs hold.
REQ-017 SHALL give flush priority over simultaneous in_valid/out_ready; no transfer occurs in a flush cycle.
REQ-018 SHALL update occupancy registered: equals popcount of valid bits (+ skid entry when present) after each edge; never exceeds DEPTH (+1).
REQ-019 SHALL accept a new word into a full pipe in the same cycle the output transfers (simultaneous push/pop keeps occupancy).

Reset
REQ-020 SHALL on rst_n=0 clear all valid bits, all data regs to zero, occupancy to 0, skid entry empty.
REQ-021 SHALL hold in_ready=0 and out_valid=0 while rst_n=0; reset overrides flush and any handshake mid-operation.
REQ-022 SHALL resume with in_ready=1 the first cycle after rst_n returns high.

Configuration
REQ-023 SHALL, with macro ELASTIC_PIPE_SKID_EN defined, add one skid entry ahead of stage 0 and drive in_ready from a register (= skid empty), removing the out_ready -> in_ready combinational path.
REQ-024 SHALL, with skid enabled, bypass the skid when empty and stage 0 accepts (latency stays DEPTH), capture into skid when stage 0 stalls, and drain skid before new input.
REQ-025 SHALL, without the macro, contain no skid storage and behave per REQ-013.

Structure
REQ-026 SHALL place CNT_W computation function and a handshake-fire helper constant set in shared package gpu_pipe_pkg.
REQ-027 SHALL implement one stage as sub-module elastic_stage (valid bit, data reg, advance logic), instantiated DEPTH times via generate.

Verification
REQ-028 SHALL cover: DEPTH=2, WIDTH=64, out_ready=1, push 0x1..0x8 back-to-back -> out_data 0x1..0x8 on cycles 3..10, no bubbles.
REQ-029 SHALL cover: fill DEPTH=4 with out_ready=0 -> occupancy 4, in_ready=0, out_data holds first word; release -> all 4 drained in order.
REQ-030 SHALL cover: full pipe, in_valid=1 and out_ready=1 same cycle -> one in, one out, occupancy stays DEPTH.
REQ-031 SHALL cover: flush with 3 words held plus in_valid=1 -> no transfer that cycle, occupancy 0 next cycle, out_valid=0.
REQ-032 SHALL cover: rst_n=0 mid-stream with out_ready=0 -> next cycle out_valid=0, out_data=0, occupancy 0; rst_n=1 -> in_ready=1.
REQ-033 SHALL cover: skid build, random in_valid/out_ready 10k cycles -> scoreboard order match, in_ready only changes on clock edge.

Source files
------------

// File: rtl/gpu_pipe_pkg.sv
// Shared helpers for the valid/ready pipeline blocks: occupancy counter width
// and a handshake classification used to detect word transfers.
package gpu_pipe_pkg;

  typedef enum logic [1:0] {
    HS_IDLE  = 2'b00,
    HS_READY = 2'b01,
    HS_STALL = 2'b10,
    HS_FIRE  = 2'b11
  } hs_e;

  // Occupancy must represent 0..DEPTH+1 so the skid entry always fits.
  function automatic int cntWidth(input int depth);
    return $clog2(depth + 2);
  endfunction

  function automatic logic hsFire(input logic valid, input logic ready);
    return hs_e'({valid, ready}) == HS_FIRE;
  endfunction

endpackage

// File: rtl/elastic_pipe_if.sv
// Upstream and downstream valid/ready channels of the elastic pipe.
// The slave modport is the pipe itself; master is the surrounding logic.
interface elastic_pipe_if #(
  parameter int WIDTH = 64
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/elastic_pipe_stage.sv
// One register stage of the elastic pipe: valid bit plus data register that
// advance when the stage enable allows, cleared by flush or reset.
module elastic_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             en_i,
  input  logic             upValid_i,
  input  logic [WIDTH-1:0] upData_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Flush drops the word but leaves the data register untouched.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (en_i) begin
      valid_d = upValid_i;
      if (upValid_i) begin
        data_d = upData_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/elastic_pipe.sv
// DEPTH-stage bubble-collapsing valid/ready pipeline with flush and occupancy.
// Defining ELASTIC_PIPE_SKID_EN adds a skid entry so in_ready is registered.
module elastic_pipe
  import gpu_pipe_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CNT_W = cntWidth(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  elastic_pipe_if.slave    bus,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0] stageValid;
  logic [DEPTH-1:0] stageEn;
  logic [WIDTH-1:0] stageData [DEPTH];
  logic             srcValid;
  logic [WIDTH-1:0] srcData;
  logic             inReady;
  logic             outValid;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] occ_q, occ_d;

`ifdef ELASTIC_PIPE_SKID_EN
  logic             skidValid_q, skidValid_d;
  logic [WIDTH-1:0] skidData_q, skidData_d;

  assign inReady  = rst_n & ~flush & ~skidValid_q;
  assign push     = hsFire(bus.in_valid, inReady);
  assign srcValid = skidValid_q | push;
  assign srcData  = skidValid_q ? skidData_q : bus.in_data;

  // A held skid word always goes first; new input bypasses only when empty.
  always_comb begin
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    if (flush) begin
      skidValid_d = 1'b0;
    end else if (skidValid_q) begin
      if (stageEn[0]) begin
        skidValid_d = 1'b0;
      end
    end else if (push && !stageEn[0]) begin
      skidValid_d = 1'b1;
      skidData_d  = bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
    end else begin
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
    end
  end
`else
  assign inReady  = rst_n & ~flush & stageEn[0];
  assign push     = hsFire(bus.in_valid, inReady);
  assign srcValid = push;
  assign srcData  = bus.in_data;
`endif

  // A stage may load whenever it is empty or everything ahead of it moves.
  always_comb begin
    stageEn = '0;
    stageEn[DEPTH-1] = ~stageValid[DEPTH-1] | bus.out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      stageEn[i] = ~stageValid[i] | stageEn[i+1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : gStage
    logic             upValid;
    logic [WIDTH-1:0] upData;
    if (i == 0) begin : gFirst
      assign upValid = srcValid;
      assign upData  = srcData;
    end else begin : gNext
      assign upValid = stageValid[i-1];
      assign upData  = stageData[i-1];
    end
    elastic_stage #(.WIDTH(WIDTH)) uStage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_i   (flush),
      .en_i      (stageEn[i]),
      .upValid_i (upValid),
      .upData_i  (upData),
      .valid_o   (stageValid[i]),
      .data_o    (stageData[i])
    );
  end

  assign outValid      = rst_n & ~flush & stageValid[DEPTH-1];
  assign pop           = hsFire(outValid, bus.out_ready);
  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_data  = stageData[DEPTH-1];

  // Bubbles moving forward never change the count; only transfers do.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (push && !pop) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe: directed scenarios plus a long random run checked
// against a word-queue model of the pipe's latency and flow-control rules.
module tb_elastic_pipe;
  import gpu_pipe_pkg::*;

  localparam int WIDTH  = 64;
  localparam int DEPTH  = 4;
  localparam int DEPTH2 = 2;
  localparam int CW     = cntWidth(DEPTH);
  localparam int CW2    = cntWidth(DEPTH2);
`ifdef ELASTIC_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, flush, rst2N, flush2;
  logic [CW-1:0]  occupancy;
  logic [CW2-1:0] occupancy2;

  elastic_pipe_if #(.WIDTH(WIDTH)) bus ();
  elastic_pipe_if #(.WIDTH(WIDTH)) bus2 ();

  elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH2)) dut2 (
    .clk       (clk),
    .rst_n     (rst2N),
    .flush     (flush2),
    .bus       (bus2),
    .occupancy (occupancy2)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    int               acceptEdge;
  } word_t;

  word_t model[$];
  int    edgeCnt;
  int    total;
  int    bad;
  int    readyPct;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // The model holds accepted words in order; a word becomes visible DEPTH-1
  // edges after acceptance once every older word has left.
  task automatic applyStimulus(input logic iv, input logic orr, input logic fl,
                               input logic rn, input logic [WIDTH-1:0] dat);
    logic  expIn;
    logic  expOv;
    word_t w;
    @(posedge clk);
    #1;
    bus.in_valid  = iv;
    bus.out_ready = orr;
    bus.in_data   = dat;
    flush         = fl;
    rst_n         = rn;
    @(negedge clk);
    if (SKID) expIn = rn && !fl && (model.size() <= DEPTH);
    else      expIn = rn && !fl && ((model.size() < DEPTH) || orr);
    expOv = 1'b0;
    if (model.size() > 0) expOv = rn && !fl && ((edgeCnt - model[0].acceptEdge) >= DEPTH - 1);
    checkOutput("in_ready", 64'(bus.in_ready), 64'(expIn));
    checkOutput("out_valid", 64'(bus.out_valid), 64'(expOv));
    if (expOv) checkOutput("out_data", 64'(bus.out_data), 64'(model[0].data));
    if (rn) checkOutput("occupancy", 64'(occupancy), 64'(model.size()));
    edgeCnt++;
    if (!rn || fl) begin
      model.delete();
    end else begin
      if (expOv && orr) void'(model.pop_front());
      if (expIn && iv) begin
        w.data       = dat;
        w.acceptEdge = edgeCnt;
        model.push_back(w);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    edgeCnt = 0;
    readyPct = 50;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data = '0;
    rst2N = 1'b0;
    flush2 = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.out_ready = 1'b1;
    bus2.in_data = '0;

    // Two-stage pipe streaming 1..8 back to back with the sink always ready.
    repeat (2) @(posedge clk);
    #1;
    rst2N = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      int pushed;
      int popped;
      bus2.in_valid = (c <= 8);
      bus2.in_data  = 64'(c);
      pushed = (c - 1 < 8) ? c - 1 : 8;
      popped = (c - 3 < 0) ? 0 : ((c - 3 > 8) ? 8 : c - 3);
      @(negedge clk);
      checkOutput("d2_in_ready", 64'(bus2.in_ready), 64'(1));
      checkOutput("d2_out_valid", 64'(bus2.out_valid), 64'((c >= 3) && (c <= 10)));
      if ((c >= 3) && (c <= 10)) checkOutput("d2_out_data", bus2.out_data, 64'(c - 2));
      checkOutput("d2_occupancy", 64'(occupancy2), 64'(pushed - popped));
      @(posedge clk);
      #1;
    end
    bus2.in_valid = 1'b0;

    // Reset, then resume with in_ready high and zeroed data.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 64'hdead);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    checkOutput("reset_data", bus.out_data, 64'h0);
    checkOutput("reset_occ", 64'(occupancy), 64'h0);

    // Fill with the sink stalled, hold, then drain in order.
    for (int k = 1; k <= DEPTH; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 64'(k));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    checkOutput("full_occ", 64'(occupancy), 64'(DEPTH));
    checkOutput("stall_head", bus.out_data, 64'h1);
    for (int k = 0; k < DEPTH + 2; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);

    // Full pipe with simultaneous push and pop.
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 64'h11 + 64'(k));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 64'h99);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    checkOutput("pushpop_occ", 64'(occupancy), 64'(DEPTH));
    checkOutput("pushpop_head", bus.out_data, 64'h12);

    // Flush with three words held and a push offered.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 64'h77);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    checkOutput("flush_occ", 64'(occupancy), 64'h0);
    checkOutput("flush_out_valid", 64'(bus.out_valid), 64'h0);

    // Reset mid-stream while the sink is stalled.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 64'ha0 + 64'(k));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 64'hbb);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    checkOutput("midrst_data", bus.out_data, 64'h0);
    checkOutput("midrst_valid", 64'(bus.out_valid), 64'h0);

    // Long random traffic with varying sink pressure, rare flushes and resets.
    for (int n = 0; n < 10000; n++) begin
      if ((n % 500) == 0) readyPct = int'($urandom_range(5, 95));
      applyStimulus($urandom_range(0, 99) < 70,
                    int'($urandom_range(0, 99)) < readyPct,
                    $urandom_range(0, 59) == 0,
                    $urandom_range(0, 299) != 0,
                    {$urandom(), $urandom()});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
